n_ones_sequencer: RTL
=====================

// Module: n_ones_sequencer
// PURPOSE
//  Streams a W-bit word out as a sequence of beats. Each beat carries up to N set bits, taken MSB-first.
//  Wraps find_first_n_ones: each beat applies it once to a residue register, then clears the bits it emitted.
//  Sits between a bit-mask producer (e.g. a unary/run-length field scanner) and a consumer that
//  can handle at most N positions per cycle.
//  Valid/ready on both sides; holds one word in flight.
// PARAMETERS
//  W  8  word width in bits (>=2)
//  N  2  max set bits emitted per beat (1..W)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  in_valid   in   1           in_data valid
//  in_ready   out  1           sequencer can accept a word this cycle
//  in_data    in   W           word to decompose
//  out_valid  out  1           out_mask/out_last valid
//  out_ready  in   1           consumer accepts current beat
//  out_mask   out  W           up to N highest remaining set bits of residue
//  out_last   out  1           this beat empties the word
//  out_count  out  $clog2(N+1) popcount(out_mask); present only with N_ONES_COUNT_EN
// BEHAVIOUR
//  - Reset (rst_n low, async): state=IDLE, residue=0, out_valid=0, in_ready=1.
//  - Reset clear: next clk edge after rst_n rises.
//  - States:
//    - IDLE: out_valid=0, in_ready=1.
//    - BUSY: out_valid=1.
//  - Accept when in_valid && in_ready: residue<=in_data, state<=BUSY.
//    - First beat is visible the cycle after accept (latency 1); no output is combinational from in_data.
//  - In BUSY:
//    - out_mask = find_first_n_ones(residue).
//    - out_last = ((residue & ~out_mask) == 0).
//  - Beat handshake (out_valid && out_ready):
//    - residue <= residue & ~out_mask.
//    - If out_last: state<=IDLE, unless a new word is accepted the same cycle.
//  - in_ready = IDLE || (out_valid && out_ready && out_last).
//    - On the last-beat handshake, a word offered that cycle loads directly.
//    - state stays BUSY; no bubble.
//    - This is the only comb path out_ready->in_ready.
//  - Zero word: in_data==0 still yields exactly one beat: out_mask=0, out_last=1.
//  - Beat count per word: max(1, ceil(popcount(in_data)/N)).
//  - Backpressure: while out_valid && !out_ready, residue, out_mask and out_last are held stable.
//  - out_valid never drops without a handshake, except on reset.
//  - in_valid while BUSY and not on the last handshake: ignored, not consumed; upstream must hold it.
//  - All-ones word, N>=W: single beat, out_mask=all ones, out_last=1.
//  - Reset mid-word: residue discarded.
//    - out_valid falls asynchronously with rst_n.
//    - No residual beats after release.
//  - out_mask bits are always a subset of the accepted word; successive beats of a word are disjoint.
//    - Their OR equals in_data.
// CONFIGURATION
//  - N_ONES_COUNT_EN defined: out_count port exists.
//    - out_count = number of ones in out_mask (0..N).
//    - Valid whenever out_valid; 0 in IDLE and during reset.
//  - N_ONES_COUNT_EN undefined: no out_count port; no popcount logic.
//    - Other behaviour identical.
// TESTING (W=8, N=2)
//  1. Accept 8'b1011_0010, out_ready=1.
//     -> 1010_0000 last=0, then 0001_0010 last=1; in_ready high on 2nd beat.
//  2. Accept 8'h00.
//     -> one beat: mask 8'h00, last=1 (count=0 if COUNT_EN); then IDLE.
//  3. Accept 8'hF0, out_ready low 3 cycles.
//     -> mask 1100_0000 held 3 cycles; residue unchanged; then 0011_0000 last=1.
//  4. 8'hC0 then 8'h01 back-to-back, in_valid held, out_ready=1.
//     -> 1100_0000 last=1 at cyc1; 0000_0001 last=1 at cyc2; no bubble.
//  5. Accept 8'hFF; after 1st beat (1100_0000) pulse rst_n low.
//     -> out_valid=0 immediately; in_ready=1; no further beats after release.
//  6. COUNT_EN, accept 8'h80.
//     -> single beat mask 1000_0000, count=1, last=1.

Source files
------------

// File: rtl/n_ones_sequencer.sv
// Splits a word into beats of up to N set bits each, highest bits first, with valid/ready on both sides.
// Define N_ONES_COUNT_EN to add the out_count port, which gives the popcount of each beat.
module n_ones_sequencer #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_mask,
  output logic         out_last
`ifdef N_ONES_COUNT_EN
  ,
  output logic [$clog2(N+1)-1:0] out_count
`endif
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] NMAX = CW'(N);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [W-1:0]  residue;
  logic [W-1:0]  sel;
  logic [CW-1:0] selcnt;
  logic          busy;
  logic          beat;
  logic          accept;

  // find_first_n_ones: scan from the MSB, keeping set bits until N have been taken
  always_comb begin : find_first_n_ones
    sel    = '0;
    selcnt = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (residue[i] && (selcnt < NMAX)) begin
        sel[i] = 1'b1;
        selcnt = selcnt + CW'(1);
      end
    end
  end

  always_comb begin
    busy      = (state == BUSY);
    out_valid = busy;
    out_mask  = busy ? sel : '0;
    out_last  = busy && ((residue & ~sel) == '0);
    beat      = out_valid && out_ready;
    in_ready  = !busy || (beat && out_last);
    accept    = in_valid && in_ready;
  end

`ifdef N_ONES_COUNT_EN
  assign out_count = busy ? selcnt : '0;
`endif

  // A new word loads on the final beat's handshake, so back-to-back words leave no idle cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      residue <= '0;
    end else if (accept) begin
      state   <= BUSY;
      residue <= in_data;
    end else if (beat) begin
      residue <= residue & ~sel;
      if (out_last) begin
        state <= IDLE;
      end
    end
  end

endmodule
